// File: rtl/ram_share_ctrl_pkg.sv
// Shared types and constants for the shared-RAM controller.
package ram_share_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RAM_RD_LAT = 1;

    function automatic int ptr_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/ram_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after rr_ptr.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic             valid_o
);

    int best_d;
    int d;

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        best_d  = N_REQ;
        d       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // distance from the pointer, wrapping modulo N_REQ
            d = i - int'(rr_ptr_i);
            if (d < 0) d = d + N_REQ;
            if (eligible_i[i] && d < best_d) begin
                best_d   = d;
                win_o    = '0;
                win_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_share_ctrl.sv
// Round-robin sharing of one single-port synchronous RAM, with clear-on-reset.
module ram_share_ctrl
    import ram_share_ctrl_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_din,
    output logic                    mem_wr,
    input  logic [DATA_W-1:0]       mem_dout
);

    localparam int PTR_W = ptr_w(N_REQ);
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_nreq
        $error("ram_share_ctrl: N_REQ must be 2..4");
    end
    if (ADDR_W < 1 || DATA_W < 1) begin : g_bad_width
        $error("ram_share_ctrl: ADDR_W and DATA_W must be >= 1");
    end
    if (RAM_RD_LAT != 1) begin : g_bad_lat
        $error("ram_share_ctrl: rvalid pipeline assumes 1-cycle RAM");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [N_REQ-1:0]    gnt_q, rvalid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                mem_wr_q;

    logic [N_REQ-1:0]    eligible, win;
    logic                win_vld;
    logic [PTR_W-1:0]    sel_idx, ptr_nxt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_din;
    logic                sel_we;

    assign eligible = req & ~gnt_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .win_o      (win),
        .valid_o    (win_vld)
    );

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                sel_idx  = PTR_W'(i);
                sel_addr = addr[i*ADDR_W +: ADDR_W];
                sel_din  = wdata[i*DATA_W +: DATA_W];
                sel_we   = we[i];
            end
        end
        ptr_nxt = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && clr_cnt_q == CLR_LAST) state_d = ST_RUN;
    end

    always_comb begin
        busy = (state_q == ST_INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            // read tag follows the grant by one cycle; writes never tag
            rvalid_q <= gnt_q & {N_REQ{~mem_wr_q}};
            if (state_q == ST_INIT) begin
                mem_wr_q   <= 1'b1;
                mem_addr_q <= clr_cnt_q;
                mem_din_q  <= '0;
                clr_cnt_q  <= clr_cnt_q + 1'b1;
                gnt_q      <= '0;
            end else begin
                gnt_q    <= win;
                mem_wr_q <= win_vld & sel_we;
                if (win_vld) begin
                    mem_addr_q <= sel_addr;
                    mem_din_q  <= sel_din;
                    rr_ptr_q   <= ptr_nxt;
                end
            end
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = mem_dout;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Directed bench for ram_share_ctrl: 2-requester main DUT, 3-requester fairness DUT.
module tb_ram_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, rst3_n;

    logic [1:0] req2, we2, gnt2, rvalid2, rdata2;
    logic [3:0] addr2, wdata2;
    logic       busy2, mem_wr2;
    logic [1:0] mem_addr2, mem_din2, mem_dout2;

    logic [2:0] req3, we3, gnt3, rvalid3;
    logic [5:0] addr3, wdata3;
    logic [1:0] rdata3, mem_addr3, mem_din3, mem_dout3;
    logic       busy3, mem_wr3;

    logic [1:0] mem2 [0:3];
    logic [1:0] mem3 [0:3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_share_ctrl #(.N_REQ(2), .ADDR_W(2), .DATA_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we2),
        .addr(addr2), .wdata(wdata2), .gnt(gnt2), .rvalid(rvalid2),
        .rdata(rdata2), .busy(busy2), .mem_addr(mem_addr2),
        .mem_din(mem_din2), .mem_wr(mem_wr2), .mem_dout(mem_dout2)
    );

    ram_share_ctrl #(.N_REQ(3), .ADDR_W(2), .DATA_W(2)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req(req3), .we(we3),
        .addr(addr3), .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3),
        .rdata(rdata3), .busy(busy3), .mem_addr(mem_addr3),
        .mem_din(mem_din3), .mem_wr(mem_wr3), .mem_dout(mem_dout3)
    );

    // RAM models: registered read returning old data on a write cycle
    always @(posedge clk) begin
        if (mem_wr2) mem2[mem_addr2] <= mem_din2;
        mem_dout2 <= mem2[mem_addr2];
        if (mem_wr3) mem3[mem_addr3] <= mem_din3;
        mem_dout3 <= mem3[mem_addr3];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [3];
        int rep, w;
        logic [1:0] exp_g, prev_g;
        logic [2:0] eg3, pg3;

        rst_n = 1'b0; rst3_n = 1'b0;
        req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy2, 1);
        check("rst_gnt", gnt2, 0);
        check("rst_rvalid", rvalid2, 0);
        check("rst_memwr", mem_wr2, 0);
        check("rst_memaddr", mem_addr2, 0);

        // 1: clear sequence, req0 pending through INIT
        rst_n = 1'b1;
        req2 = 2'b01; we2 = 2'b00; addr2 = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("init_wr", mem_wr2, 1);
            check("init_addr", mem_addr2, c - 1);
            check("init_din", mem_din2, 0);
            check("init_busy", busy2, (c < 4) ? 1 : 0);
            check("init_gnt", gnt2, 0);
        end
        @(negedge clk);
        check("t1_gnt", gnt2, 2'b01);
        check("t1_memwr", mem_wr2, 0);
        req2 = 2'b00;
        @(negedge clk);
        check("t1_rvalid", rvalid2, 2'b01);
        check("t1_rdata", rdata2, 0);
        check("t1_gnt_off", gnt2, 0);

        // 2: write addr2=2'b10, then read it back
        req2 = 2'b01; we2 = 2'b01; addr2 = 4'h2; wdata2 = 4'h2;
        @(negedge clk);
        check("t2_wgnt", gnt2, 2'b01);
        check("t2_memwr", mem_wr2, 1);
        check("t2_memaddr", mem_addr2, 2);
        check("t2_memdin", mem_din2, 2);
        we2 = 2'b00;
        @(negedge clk);
        check("t2_mask_gnt", gnt2, 0);
        check("t2_w_norv", rvalid2, 0);
        @(negedge clk);
        check("t2_rgnt", gnt2, 2'b01);
        check("t2_rd_memwr", mem_wr2, 0);
        req2 = 2'b00;
        @(negedge clk);
        check("t2_rvalid", rvalid2, 2'b01);
        check("t2_rdata", rdata2, 2);

        // 3: both reading: req0 addr2 (=2), req1 addr0 (=0); ptr is at 1
        req2 = 2'b11; we2 = 2'b00; addr2 = {2'd0, 2'd2};
        prev_g = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            check("t3_gnt", gnt2, exp_g);
            check("t3_rvalid", rvalid2, prev_g);
            if (prev_g != 2'b00)
                check("t3_rdata", rdata2, (prev_g == 2'b01) ? 2 : 0);
            prev_g = exp_g;
        end
        req2 = 2'b00;
        @(negedge clk);
        check("t3_last_rv", rvalid2, 2'b01);
        check("t3_last_rd", rdata2, 2);
        check("t3_idle", gnt2, 0);

        // 4: req1 writes addr1=3, req0 reads addr1 on the next grant
        req2 = 2'b11; we2 = 2'b10; addr2 = {2'd1, 2'd1}; wdata2 = {2'd3, 2'd0};
        @(negedge clk);
        check("t4_wgnt", gnt2, 2'b10);
        check("t4_memwr", mem_wr2, 1);
        check("t4_memaddr", mem_addr2, 1);
        check("t4_memdin", mem_din2, 3);
        req2 = 2'b01;
        @(negedge clk);
        check("t4_rgnt", gnt2, 2'b01);
        check("t4_rd_memwr", mem_wr2, 0);
        req2 = 2'b00;
        @(negedge clk);
        check("t4_rvalid", rvalid2, 2'b01);
        check("t4_rdata", rdata2, 3);

        // 5: reset while req1 read of addr2 is granted
        req2 = 2'b10; we2 = 2'b00; addr2 = {2'd2, 2'd0};
        @(negedge clk);
        check("t5_gnt", gnt2, 2'b10);
        rst_n = 1'b0;
        req2 = 2'b00;
        #1;
        check("t5_async_gnt", gnt2, 0);
        check("t5_async_busy", busy2, 1);
        @(negedge clk);
        check("t5_no_rv", rvalid2, 0);
        check("t5_rst_memwr", mem_wr2, 0);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t5_init_rv", rvalid2, 0);
            check("t5_init_wr", mem_wr2, 1);
            check("t5_init_busy", busy2, (c < 4) ? 1 : 0);
        end
        req2 = 2'b11; we2 = 2'b00; addr2 = {2'd2, 2'd1};
        @(negedge clk);
        check("t5_gnt0", gnt2, 2'b01);
        check("t5_rv_idle", rvalid2, 0);
        req2 = 2'b10;
        @(negedge clk);
        check("t5_gnt1", gnt2, 2'b10);
        check("t5_rv0", rvalid2, 2'b01);
        check("t5_rd_addr1", rdata2, 0);
        req2 = 2'b00;
        @(negedge clk);
        check("t5_rv1", rvalid2, 2'b10);
        check("t5_rd_addr2", rdata2, 0);

        // 6: three-way fairness over 30 grant cycles
        rst3_n = 1'b1;
        req3 = 3'b111; we3 = 3'b000; addr3 = 6'h0;
        w = 0;
        while (busy3 !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t6_busy_done", busy3, 0);
        cnt = '{0, 0, 0};
        rep = 0;
        pg3 = 3'b000;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            eg3 = 3'b001 << (k % 3);
            check("t6_gnt", gnt3, eg3);
            for (int i = 0; i < 3; i++)
                if (gnt3[i]) cnt[i]++;
            if (gnt3 != 3'b000 && gnt3 == pg3) rep++;
            pg3 = gnt3;
        end
        req3 = 3'b000;
        check("t6_cnt0", cnt[0], 10);
        check("t6_cnt1", cnt[1], 10);
        check("t6_cnt2", cnt[2], 10);
        check("t6_repeats", rep, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
